// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: run/program mode sequencer and single memory port mux; optional session write counter under MEM_ARB_WR_COUNT_EN
module mem_port_arbiter #(
  parameter int REGISTER_WIDTH = 4,
  parameter int MEMORY_ADDRESS_WIDTH = 4
) (
  input  logic                            clk_i,
  input  logic                            reset_ni,
  input  logic                            prog_active_i,
  input  logic                            prog_we_i,
  input  logic [MEMORY_ADDRESS_WIDTH-1:0] prog_addr_i,
  input  logic [REGISTER_WIDTH-1:0]       prog_data_i,
  input  logic                            cpu_req_i,
  input  logic                            cpu_we_i,
  input  logic [MEMORY_ADDRESS_WIDTH-1:0] cpu_addr_i,
  input  logic [REGISTER_WIDTH-1:0]       cpu_data_i,
  output logic                            cpu_gnt_o,
  output logic [REGISTER_WIDTH-1:0]       cpu_rdata_o,
  output logic                            cpu_rvalid_o,
  output logic                            cpu_halt_o,
  output logic                            prog_done_o,
  output logic [MEMORY_ADDRESS_WIDTH:0]   prog_wr_count_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr_o,
  output logic [REGISTER_WIDTH-1:0]       mem_data_o,
  output logic                            mem_we_o,
  input  logic [REGISTER_WIDTH-1:0]       mem_rdata_i
);
  typedef enum logic [1:0] {stRUN, stDRAIN, stPROG, stRELEASE} state_t;
  state_t state, state_nx;
  logic prog_wr, cpu_load;
  assign prog_wr = prog_we_i & prog_active_i;
  assign cpu_gnt_o = reset_ni & cpu_req_i & (state == stRUN) & !prog_active_i & !prog_wr;
  assign cpu_load = cpu_gnt_o & !cpu_we_i;
  assign mem_we_o = reset_ni & (prog_wr | (cpu_gnt_o & cpu_we_i));
  assign mem_addr_o = prog_wr ? prog_addr_i : cpu_gnt_o ? cpu_addr_i : '0;
  assign mem_data_o = prog_wr ? prog_data_i : cpu_gnt_o ? cpu_data_i : '0;
  // next mode: drain and release are single-cycle transit states
  always_comb begin
    state_nx = state;
    case (state)
      stRUN:   state_nx = prog_active_i ? stDRAIN : stRUN;
      stDRAIN: state_nx = stPROG;
      stPROG:  state_nx = prog_active_i ? stPROG : stRELEASE;
      default: state_nx = stRUN;
    endcase
  end
  // mode register with halt and done registered from the next mode
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state       <= stRUN;
      cpu_halt_o  <= 1'b0;
      prog_done_o <= 1'b0;
    end else begin
      state       <= state_nx;
      cpu_halt_o  <= state_nx != stRUN;
      prog_done_o <= state_nx == stRELEASE;
    end
  end
  // load return path: capture read data one cycle after a granted load
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      cpu_rvalid_o <= 1'b0;
      cpu_rdata_o  <= '0;
    end else begin
      cpu_rvalid_o <= cpu_load;
      if (cpu_load) cpu_rdata_o <= mem_rdata_i;
    end
  end
`ifdef MEM_ARB_WR_COUNT_EN
  logic [MEMORY_ADDRESS_WIDTH:0] wr_count;
  // session write counter: cleared when leaving run mode, saturating
  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) wr_count <= '0;
    else if (state == stRUN && prog_active_i) wr_count <= '0;
    else if (prog_wr && wr_count != '1) wr_count <= wr_count + 1'b1;
  end
  assign prog_wr_count_o = wr_count;
`else
  assign prog_wr_count_o = '0;
`endif
endmodule
